lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit in the EX->MEM boundary; consumes the ALU's address result for _LB/_LH/_LW/_LBU/_LHU/_SB/_SH/_SW.
//  Drives a req/gnt/rvalid data-memory port: byte-lane alignment, write strobes, load extension, misalign detection.
//  Stalls the core pipeline until the access retires; non-memory ops pass through without stall.
// PARAMETERS
//  GNT_TIMEOUT  0   cycles waiting for mem_gnt_i before abort with err_o; 0 = wait forever
//  CNT_W        8   width of timeout counter; GNT_TIMEOUT < 2**CNT_W
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_i           in   1   reset, asynchronous, active-high
//  valid_i         in   1   EX instruction valid; held stable by core while stall_o=1
//  op_i            in   OPERATOR_t  decoded operator
//  addr_i          in   32  byte address (ALU add_result)
//  wdata_i         in   32  store source (rs2)
//  stall_o         out  1   hold pipeline
//  done_o          out  1   1-cycle pulse: access retired (or aborted)
//  rdata_o         out  32  extended load data, valid with done_o on loads
//  err_o           out  1   with done_o: misaligned or grant timeout
//  mem_req_o       out  1   memory request
//  mem_we_o        out  1   1=store
//  mem_addr_o      out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wstrb_o     out  4   byte write strobes
//  mem_wdata_o     out  32  lane-replicated store data
//  mem_gnt_i       in   1   request accepted this cycle
//  mem_rvalid_i    in   1   load data valid
//  mem_rdata_i     in   32  raw load word
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; captured op/addr/data/counter cleared. Async reset mid-access aborts it; no done_o.
//  States: IDLE, REQ, RESP, DONE.
//  IDLE: valid_i & mem-op -> capture op/addr/wdata; misaligned -> DONE (err); else -> REQ. Non-mem op: stay, no stall.
//  REQ: mem_req_o=1, we/addr/wstrb/wdata stable from captured regs. gnt & store -> DONE; gnt & load -> RESP.
//   Timeout count per cycle in REQ without gnt; reaching GNT_TIMEOUT -> DONE with err, req drops.
//  RESP: mem_req_o=0; mem_rvalid_i -> register extended data, -> DONE. rvalid never same cycle as gnt.
//  DONE: done_o=1, stall_o=0, one cycle; valid_i ignored (same instr still present) -> IDLE.
//  stall_o = (IDLE & valid_i & mem-op) | REQ | RESP  (combinational, so stalls from the accept cycle).
//  Latency (no wait states): store gnt in first REQ cycle -> done_o 2 cycles after accept; load rvalid next cycle -> 3.
//  Misaligned: LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0; byte ops never misaligned. No memory request issued.
//  Store: SB wstrb=4'b0001<<a[1:0], wdata={4{b}}; SH wstrb=4'b0011<<a[1:0], wdata={2{h}}; SW 4'b1111, wdata_i.
//  Load: select lane by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; rdata_o held until next load retire.
//  err_o only asserted with done_o; rdata_o undefined-but-unchanged on err.
//  Unexpected mem_gnt_i/mem_rvalid_i outside REQ/RESP: ignored.
// STRUCTURE
//  Shared package: lsu_state_t enum, is_mem_op/is_load helpers over OPERATOR_t (OPERATOR_t already there).
//  Sub-module lsu_align (combinational): store strobe/replication + load lane select/extension; FSM+counter in top.
// TESTING
//  SW addr 0x100, wdata 0xDEADBEEF, gnt at once -> req we=1 addr 0x100 wstrb F, done_o 2 cycles after accept, err 0.
//  SB addr 0x103 wdata 0x000000A5 -> wstrb 4'b1000, wdata 0xA5A5A5A5.
//  LB addr 0x202, rdata_i 0x0080FF00, gnt delayed 3 cycles -> stall 5+ cycles, rdata_o 0xFFFFFF80; LBU same -> 0x80.
//  LH addr 0x201 -> no mem_req_o, done_o next cycle with err_o=1; LHU 0x202 rdata 0x8001xxxx -> 0x00008001.
//  GNT_TIMEOUT=4, gnt never -> req high 4 cycles, then done_o+err_o; rst_i pulse in RESP -> IDLE, all outputs 0.
//  Back-to-back SW then LW -> second accepted cycle after DONE; ADD with valid_i -> stall_o stays 0.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared types and decode helpers for the load/store unit.
// OPERATOR_t is the core's decoded-operator enum; the LSU only reacts to the memory operators.
package lsu_ctrl_pkg;

   localparam int XLEN      = 32;
   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;

   typedef enum logic [4:0] {
      _ADD, _SUB, _AND, _OR, _XOR, _SLL, _SRL, _SRA, _SLT, _SLTU,
      _LB, _LH, _LW, _LBU, _LHU, _SB, _SH, _SW
   } OPERATOR_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} lsu_state_t;

   typedef struct packed {
      OPERATOR_t       op;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

   function automatic logic is_load(input OPERATOR_t op);
      return op inside {_LB, _LH, _LW, _LBU, _LHU};
   endfunction

   function automatic logic is_store(input OPERATOR_t op);
      return op inside {_SB, _SH, _SW};
   endfunction

   function automatic logic is_mem_op(input OPERATOR_t op);
      return is_load(op) | is_store(op);
   endfunction

   // Byte accesses can never be misaligned.
   function automatic logic is_misaligned(input OPERATOR_t op, input logic [1:0] off);
      case (op)
         _LH, _LHU, _SH: return off[0];
         _LW, _SW:       return |off;
         default:        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering: store strobes/replication and load lane select with extension.
// Purely combinational; strobes are zero for non-store operators.
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  OPERATOR_t              op_i,
   input  logic [1:0]             off_i,
   input  logic [XLEN-1:0]        wdata_i,
   input  logic [XLEN-1:0]        rdata_i,
   output logic [NUM_LANES-1:0]   wstrb_o,
   output logic [XLEN-1:0]        wdata_o,
   output logic [XLEN-1:0]        rdata_o
);

   logic [NUM_LANES-1:0][LANE_W-1:0] wlane;
   logic [XLEN-1:0]                  shifted;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LI = 2'(i);
      assign wlane[i]   = (op_i == _SB) ? wdata_i[LANE_W-1:0] :
                          (op_i == _SH) ? wdata_i[LANE_W*(i%2) +: LANE_W] :
                                          wdata_i[LANE_W*i +: LANE_W];
      assign wstrb_o[i] = (op_i == _SW) |
                          ((op_i == _SH) & (off_i[1] == LI[1])) |
                          ((op_i == _SB) & (off_i == LI));
   end

   assign wdata_o = wlane;
   assign shifted = rdata_i >> {off_i, 3'b000};

   always_comb begin
      rdata_o = rdata_i;
      case (op_i)
         _LB:     rdata_o = {{24{shifted[7]}}, shifted[7:0]};
         _LBU:    rdata_o = {24'd0, shifted[7:0]};
         _LH:     rdata_o = {{16{shifted[15]}}, shifted[15:0]};
         _LHU:    rdata_o = {16'd0, shifted[15:0]};
         default: rdata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit at the EX->MEM boundary: drives a req/gnt/rvalid data port and
// stalls the core until the access retires. Non-memory ops pass straight through.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int unsigned GNT_TIMEOUT = 0,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  OPERATOR_t            op_i,
   input  logic [XLEN-1:0]      addr_i,
   input  logic [XLEN-1:0]      wdata_i,
   output logic                 stall_o,
   output logic                 done_o,
   output logic [XLEN-1:0]      rdata_o,
   output logic                 err_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [XLEN-1:0]      mem_addr_o,
   output logic [NUM_LANES-1:0] mem_wstrb_o,
   output logic [XLEN-1:0]      mem_wdata_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [XLEN-1:0]      mem_rdata_i
);

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(GNT_TIMEOUT);

   lsu_state_t          state_q, state_d;
   lsu_req_t            req_q, req_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;

   logic                accept, misal_in, to_hit, st_q;
   logic [NUM_LANES-1:0] al_wstrb;
   logic [XLEN-1:0]     al_wdata, al_rdata;

   lsu_align u_align (
      .op_i    (req_q.op),
      .off_i   (req_q.addr[1:0]),
      .wdata_i (req_q.wdata),
      .rdata_i (mem_rdata_i),
      .wstrb_o (al_wstrb),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata)
   );

   assign accept   = valid_i & is_mem_op(op_i);
   assign misal_in = is_misaligned(op_i, addr_i[1:0]);
   assign st_q     = is_store(req_q.op);
   // The gnt-wins-over-timeout priority falls out of checking gnt first in REQ.
   assign to_hit   = (GNT_TIMEOUT != 0) && (cnt_q == TO_LIM - 1'b1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      err_o     = 1'b0;
      mem_req_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               stall_o = 1'b1;
               req_d   = '{op: op_i, addr: addr_i, wdata: wdata_i};
               cnt_d   = '0;
               err_d   = misal_in;
               state_d = misal_in ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            stall_o   = 1'b1;
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
               state_d = is_load(req_q.op) ? S_RESP : S_DONE;
            end else if (to_hit) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            stall_o = 1'b1;
            if (mem_rvalid_i) begin
               rdata_d = al_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // The retiring instruction is still on valid_i here; it must not re-launch.
            done_o  = 1'b1;
            err_o   = err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rdata_o     = rdata_q;
   assign mem_we_o    = mem_req_o & st_q;
   assign mem_addr_o  = mem_req_o ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
   assign mem_wstrb_o = (mem_req_o & st_q) ? al_wstrb : '0;
   assign mem_wdata_o = (mem_req_o & st_q) ? al_wdata : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a transaction-level model predicts strobes, data,
// error and latency; one negedge process checks the DUT against it every cycle.
`timescale 1ns/1ps
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   OPERATOR_t   op_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   lsu_ctrl #(.GNT_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
      .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0, failures = 0, cyc_cnt = 0;
   always @(posedge clk_i) cyc_cnt++;

   // model state for the transaction in flight
   bit          active = 0;
   bit          m_load, m_we, m_err, m_misal;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [31:0] last_load = 32'd0;
   logic [3:0]  seen_wstrb;
   logic [31:0] seen_wdata;
   int          acc_cyc, done_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model(input OPERATOR_t op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd);
      int sz, sh;
      logic [31:0] mask, v;
      sh = int'(a % 4);
      case (op)
         _LB, _LBU, _SB: sz = 1;
         _LH, _LHU, _SH: sz = 2;
         default:        sz = 4;
      endcase
      mask    = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
      m_misal = (a % sz) != 0;
      m_err   = m_misal;
      m_load  = op inside {_LB, _LH, _LW, _LBU, _LHU};
      m_we    = !m_load;
      m_addr  = a & ~32'd3;
      m_wstrb = 4'(((1 << sz) - 1) << sh);
      m_wdata = (sz == 1) ? (wd & mask) * 32'h0101_0101 :
                (sz == 2) ? (wd & mask) * 32'h0001_0001 : wd;
      v = (rd >> (8*sh)) & mask;
      if ((op == _LB || op == _LH) && v[8*sz-1]) v = v | ~mask;
      m_rdata = v;
   endtask

   // per-cycle comparison against the model
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (!done_o) chk("err_without_done", err_o, 0);
         if (!active) begin
            chk("idle_stall", stall_o, 0);
            chk("idle_req", mem_req_o, 0);
            chk("idle_done", done_o, 0);
         end else begin
            if (!done_o) chk("busy_stall", stall_o, 1);
            if (m_misal) chk("misal_no_req", mem_req_o, 0);
            if (mem_req_o && !m_misal) begin
               chk("req_we", mem_we_o, m_we);
               chk("req_addr", mem_addr_o, m_addr);
               if (m_we) begin
                  chk("req_wstrb", mem_wstrb_o, m_wstrb);
                  chk("req_wdata", mem_wdata_o, m_wdata);
               end
            end
            if (done_o) begin
               chk("done_stall", stall_o, 0);
               chk("done_err", err_o, m_err);
               if (m_load && !m_err) chk("load_rdata", rdata_o, m_rdata);
               else                  chk("rdata_held", rdata_o, last_load);
            end
         end
      end
   end

   // Drives one instruction and plays the memory: gnt after gdly REQ cycles, rvalid the cycle after gnt.
   task automatic run_op(input OPERATOR_t op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int gdly,
                         output int lat, output int nstall, output int nreq);
      bit gg, rv, dn;
      int exp_lat;
      model(op, a, wd, rd);
      if (!m_misal && gdly >= TO) m_err = 1;
      exp_lat = m_misal ? 1 : (gdly >= TO) ? 1 + TO : (m_load ? 3 : 2) + gdly;
      active = 1; valid_i = 1; op_i = op; addr_i = a; wdata_i = wd;
      acc_cyc = cyc_cnt;
      lat = 0; nstall = 0; nreq = 0; gg = 0; rv = 0; dn = 0;
      #1;
      while (!dn && lat < 60) begin
         mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
         if (mem_req_o) begin
            if (nreq == gdly) begin
               mem_gnt_i = 1; gg = 1;
               seen_wstrb = mem_wstrb_o; seen_wdata = mem_wdata_o;
            end
            nreq++;
         end else if (gg && m_load && !rv) begin
            mem_rvalid_i = 1; mem_rdata_i = rd; rv = 1;
         end
         if (stall_o) nstall++;
         if (done_o) begin dn = 1; done_cyc = cyc_cnt; end
         else lat++;
         @(posedge clk_i); #1;
      end
      mem_gnt_i = 0; mem_rvalid_i = 0; valid_i = 0; op_i = _ADD;
      active = 0;
      chk("done_seen", dn, 1);
      chk("latency", lat, exp_lat);
      if (dn && m_load && !m_err) last_load = m_rdata;
   endtask

   int lat, ns, nr, d1;

   initial begin
      rst_i = 1; valid_i = 0; op_i = _ADD; addr_i = 0; wdata_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
      repeat (2) @(negedge clk_i);
      chk("rst_stall", stall_o, 0); chk("rst_done", done_o, 0);
      chk("rst_req", mem_req_o, 0); chk("rst_err", err_o, 0);
      chk("rst_rdata", rdata_o, 0); chk("rst_wstrb", mem_wstrb_o, 0);
      @(posedge clk_i); #1; rst_i = 0;
      @(posedge clk_i); #1;

      run_op(_SW, 32'h100, 32'hDEAD_BEEF, 0, 0, lat, ns, nr);
      chk("sw_lat_lit", lat, 2); chk("sw_wstrb_lit", seen_wstrb, 4'hF);
      chk("sw_wdata_lit", seen_wdata, 32'hDEAD_BEEF);
      run_op(_SB, 32'h103, 32'h0000_00A5, 0, 0, lat, ns, nr);
      chk("sb_wstrb_lit", seen_wstrb, 4'b1000); chk("sb_wdata_lit", seen_wdata, 32'hA5A5_A5A5);
      run_op(_LB, 32'h202, 0, 32'h0080_FF00, 3, lat, ns, nr);
      chk("lb_rdata_lit", rdata_o, 32'hFFFF_FF80); chk("lb_stall_lit", ns, 6);
      run_op(_LBU, 32'h202, 0, 32'h0080_FF00, 0, lat, ns, nr);
      chk("lbu_rdata_lit", rdata_o, 32'h0000_0080); chk("lbu_lat_lit", lat, 3);
      run_op(_LH, 32'h201, 0, 32'h1234_5678, 0, lat, ns, nr);
      chk("lh_misal_lat_lit", lat, 1); chk("lh_misal_nreq", nr, 0);
      run_op(_LHU, 32'h202, 0, 32'h8001_1234, 0, lat, ns, nr);
      chk("lhu_rdata_lit", rdata_o, 32'h0000_8001);
      run_op(_SH, 32'h102, 32'h1234_ABCD, 0, 2, lat, ns, nr);
      chk("sh_wstrb_lit", seen_wstrb, 4'b1100); chk("sh_wdata_lit", seen_wdata, 32'hABCD_ABCD);
      run_op(_LW, 32'h104, 0, 32'h1234_5678, 1, lat, ns, nr);
      run_op(_SW, 32'h102, 32'h1111_1111, 0, 0, lat, ns, nr);
      chk("sw_misal_rdata_lit", rdata_o, 32'h1234_5678);
      run_op(_LH, 32'h206, 0, 32'hFFFE_0000, 0, lat, ns, nr);
      chk("lh_rdata_lit", rdata_o, 32'hFFFF_FFFE);
      run_op(_LB, 32'h301, 0, 32'h0000_7F00, 0, lat, ns, nr);

      // grant never comes: req for exactly TO cycles, then error
      run_op(_LW, 32'h300, 0, 32'hCAFE_F00D, 99, lat, ns, nr);
      chk("to_nreq_lit", nr, 4); chk("to_lat_lit", lat, 5);

      // back-to-back: second op accepted in the cycle right after DONE
      run_op(_SW, 32'h500, 32'h0BAD_F00D, 0, 0, lat, ns, nr);
      d1 = done_cyc;
      run_op(_LW, 32'h504, 0, 32'h7654_3210, 0, lat, ns, nr);
      chk("b2b_accept_cyc", acc_cyc, d1 + 1);

      // non-memory op: never stalls
      valid_i = 1; op_i = _ADD; addr_i = 32'h201;
      repeat (3) begin #1; chk("add_stall", stall_o, 0); @(posedge clk_i); #1; end
      valid_i = 0;

      // stray gnt/rvalid while idle are ignored
      mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk_i);
      #1; mem_gnt_i = 0; mem_rvalid_i = 0;
      chk("stray_rdata", rdata_o, last_load);

      // async reset while waiting for rvalid
      model(_LW, 32'h400, 0, 0);
      active = 1; valid_i = 1; op_i = _LW; addr_i = 32'h400;
      @(posedge clk_i); #1; mem_gnt_i = 1;
      @(posedge clk_i); #1; mem_gnt_i = 0;
      chk("resp_stall", stall_o, 1); chk("resp_req", mem_req_o, 0);
      rst_i = 1; valid_i = 0; active = 0; last_load = 0; #1;
      chk("arst_stall", stall_o, 0); chk("arst_req", mem_req_o, 0);
      chk("arst_done", done_o, 0); chk("arst_rdata", rdata_o, 0);
      @(posedge clk_i); #1; rst_i = 0;
      repeat (2) @(posedge clk_i); #1;
      mem_rvalid_i = 1; mem_rdata_i = 32'h5555_5555;
      @(posedge clk_i); #1; mem_rvalid_i = 0;

      run_op(_LHU, 32'h600, 0, 32'h0000_BEEF, 0, lat, ns, nr);
      chk("post_rst_lhu_lit", rdata_o, 32'h0000_BEEF);

      repeat (2) @(posedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
